// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480 raster geometry (porch/sync/visible widths), counter and colour widths, bar helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a. Shared by vga_scan_ctrl and the pixel generator so both agree on the visible window.
package vga_pkg;

  localparam int CNT_W  = 10;   // scan counters; 799/524 max at default geometry
  localparam int RGB_W  = 8;    // RRRGGGBB

  // Horizontal line: back porch, visible, front porch, sync (scan origin is the back porch).
  localparam int H_BP   = 48;
  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;

  // Vertical frame, same ordering.
  localparam int V_BP   = 33;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;

  localparam int H_TOTAL_DEF = H_BP + H_VIS + H_FP + H_SYNC;  // 800
  localparam int V_TOTAL_DEF = V_BP + V_VIS + V_FP + V_SYNC;  // 525

  // Colour bars for the optional test pattern.
  localparam int BAR_W  = 80;
  localparam int N_BARS = 8;

  // x is the column relative to the first visible pixel. Bar k spreads its
  // three index bits across the R, G and B fields: {3{k[2]},3{k[1]},2{k[0]}}.
  function automatic logic [RGB_W-1:0] bar_color(input logic [CNT_W-1:0] x);
    logic [2:0] k;
    k = '0;
    for (int i = 1; i < N_BARS; i++) begin
      if (x >= CNT_W'(i * BAR_W)) k = 3'(i);
    end
    return {{3{k[2]}}, {3{k[1]}}, {2{k[0]}}};
  endfunction

endpackage

// File: rtl/vga_mod_counter.sv
// vga_mod_counter: modulo-MOD up counter with enable and a wrap pulse on the enabled terminal count.
// Latency: count updates on the clk after en; wrap is combinational (en && count == MOD-1).
// Backpressure: none; en is the only throttle.
// Ports: clk, rst_n (async, active-low), en, count (0..MOD-1), wrap.
module vga_mod_counter
  import vga_pkg::*;
#(
  parameter int MOD = 800
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster scan (col/row), colour-fetch handshake (req/next_color) and registered DAC outputs.
// Latency: each pixel spans 2 clk; req in its first clk, colour sampled at its end; rgb/hsync/vsync lag col/row by one pixel.
// Backpressure: none; the pixel generator must present next_color on the clk after every req.
// Ports: clk (2x pixel rate), rst_n (async, active-low), next_color, col, row, req, rgb (RRRGGGBB),
//   hsync/vsync (active-low), frame_start. Build option VGA_TEST_PATTERN_EN adds test_en (colour bars).
// Porch and sync widths are fixed; a non-default H_TOTAL/V_TOTAL grows or shrinks the visible area.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             test_en,
`endif
  input  logic [RGB_W-1:0] next_color,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             req,
  output logic [RGB_W-1:0] rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  localparam int H_VIS_END    = H_TOTAL - H_FP - H_SYNC;  // first front-porch column
  localparam int H_SYNC_START = H_TOTAL - H_SYNC;
  localparam int V_VIS_END    = V_TOTAL - V_FP - V_SYNC;
  localparam int V_SYNC_START = V_TOTAL - V_SYNC;

  logic             pix_ce;
  logic             col_wrap;
  logic             row_wrap;
  logic             visible;
  logic             in_hsync;
  logic             in_vsync;
  logic [RGB_W-1:0] pix_color;

  // Pixel enable: low in the first clk of a pixel (request phase), high in
  // the second (colour arrives, outputs load, counters advance).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_ce <= 1'b0;
    else        pix_ce <= ~pix_ce;
  end

  vga_mod_counter #(.MOD(H_TOTAL)) u_col (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_ce),
    .count (col),
    .wrap  (col_wrap)
  );

  // col_wrap already includes pix_ce, so the row steps once per line.
  vga_mod_counter #(.MOD(V_TOTAL)) u_row (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (col_wrap),
    .count (row),
    .wrap  (row_wrap)
  );

  assign visible  = (col >= CNT_W'(H_BP)) && (col < CNT_W'(H_VIS_END)) &&
                    (row >= CNT_W'(V_BP)) && (row < CNT_W'(V_VIS_END));
  assign in_hsync = (col >= CNT_W'(H_SYNC_START));
  assign in_vsync = (row >= CNT_W'(V_SYNC_START));

  // One clk per visible pixel; the generator answers on the pix_ce=1 clk.
  assign req = ~pix_ce & visible;

`ifdef VGA_TEST_PATTERN_EN
  // req keeps flowing in pattern mode so the generator's view stays unchanged.
  assign pix_color = test_en ? bar_color(col - CNT_W'(H_BP)) : next_color;
`else
  assign pix_color = next_color;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb         <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      // row_wrap implies the last pixel of the frame on a pix_ce edge.
      frame_start <= row_wrap;
      if (pix_ce) begin
        rgb   <= visible ? pix_color : '0;
        hsync <= ~in_hsync;
        vsync <= ~in_vsync;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: random next_color against a cycle-indexed raster model, plus directed vectors.
// A default-geometry instance covers lines, porches and the data path; a reduced-geometry
// instance (200x50) makes frame wrap, vsync and per-frame req counts reachable quickly.
module tb_vga_scan_ctrl;

  localparam int HM = 800;
  localparam int VM = 525;
  localparam int HS = 200;
  localparam int VS = 50;
`ifdef VGA_TEST_PATTERN_EN
  localparam int N_RUN = 55620;
`else
  localparam int N_RUN = 54180;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst_s;
  logic       test_en;
  logic [7:0] nc_m, nc_s;
  logic [9:0] col_m, row_m, col_s, row_s;
  logic       req_m, hs_m, vs_m, fs_m, req_s, hs_s, vs_s, fs_s;
  logic [7:0] rgb_m, rgb_s;

  vga_scan_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef VGA_TEST_PATTERN_EN
    .test_en     (test_en),
`endif
    .next_color  (nc_m),
    .col         (col_m),
    .row         (row_m),
    .req         (req_m),
    .rgb         (rgb_m),
    .hsync       (hs_m),
    .vsync       (vs_m),
    .frame_start (fs_m)
  );

  vga_scan_ctrl #(.H_TOTAL(HS), .V_TOTAL(VS)) dut_s (
    .clk         (clk),
    .rst_n       (rst_s),
`ifdef VGA_TEST_PATTERN_EN
    .test_en     (1'b0),
`endif
    .next_color  (nc_s),
    .col         (col_s),
    .row         (row_s),
    .req         (req_s),
    .rgb         (rgb_s),
    .hsync       (hs_s),
    .vsync       (vs_s),
    .frame_start (fs_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       req;
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
    logic       fs;
  } obs_t;

  // Raster rules: columns 48..H-16-96-1 and rows 33..V-10-2-1 visible;
  // last 96 columns are hsync, last 2 rows are vsync.
  function automatic bit vis_f(int c, int r, int h, int v);
    return (c >= 48) && (c < h - 16 - 96) && (r >= 33) && (r < v - 10 - 2);
  endfunction

  // Expected outputs after n clk edges since reset release. Pixel p = n/2 is
  // being scanned; the registered outputs show pixel p-1. held/pat are the
  // colour and test_en presented in the second clk of pixel p-1.
  function automatic obs_t model(int n, int h, int v, logic [7:0] held, bit pat);
    obs_t o;
    int p, c, r, q, qc, qr;
    logic [2:0] k;
    p = n / 2;
    c = p % h;
    r = (p / h) % v;
    o.col = 10'(c);
    o.row = 10'(r);
    o.req = (n % 2 == 0) && vis_f(c, r, h, v);
    o.rgb = 8'h00;
    o.hs  = 1'b1;
    o.vs  = 1'b1;
    if (n >= 2) begin
      q  = p - 1;
      qc = q % h;
      qr = (q / h) % v;
      if (vis_f(qc, qr, h, v)) begin
        if (pat) begin
          k = 3'((qc - 48) / 80);
          o.rgb = {{3{k[2]}}, {3{k[1]}}, {2{k[0]}}};
        end else begin
          o.rgb = held;
        end
      end
      o.hs = !(qc >= h - 96);
      o.vs = !(qr >= v - 2);
    end
    o.fs = (n >= 2) && (n % 2 == 0) && (p % (h * v) == 0);
    return o;
  endfunction

  task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".col"},   32'(a.col), 32'(e.col));
    chk({tag, ".row"},   32'(a.row), 32'(e.row));
    chk({tag, ".req"},   32'(a.req), 32'(e.req));
    chk({tag, ".rgb"},   32'(a.rgb), 32'(e.rgb));
    chk({tag, ".hsync"}, 32'(a.hs),  32'(e.hs));
    chk({tag, ".vsync"}, 32'(a.vs),  32'(e.vs));
    chk({tag, ".fs"},    32'(a.fs),  32'(e.fs));
  endtask

  typedef struct {
    int         n;     // edges since release when checked
    bit         frc;   // force next_color in the clk before the check
    logic [7:0] fv;
    logic [9:0] col;
    logic [9:0] row;
    logic [7:0] rgb;
    logic       hs;
  } vec_t;
  vec_t vecs[$];

  task automatic apply_vectors(input int n);
    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].n == n) begin
        chk($sformatf("vec%0d.col", k),   32'(col_m), 32'(vecs[k].col));
        chk($sformatf("vec%0d.row", k),   32'(row_m), 32'(vecs[k].row));
        chk($sformatf("vec%0d.rgb", k),   32'(rgb_m), 32'(vecs[k].rgb));
        chk($sformatf("vec%0d.hsync", k), 32'(hs_m),  32'(vecs[k].hs));
      end
    end
  endtask

  function automatic logic [7:0] forced_or_rand(input int n, input logic [7:0] r);
    logic [7:0] v;
    v = r;
    for (int k = 0; k < vecs.size(); k++)
      if (vecs[k].frc && vecs[k].n == n + 1) v = vecs[k].fv;
    return v;
  endfunction

  logic [7:0] held_m, held_s;
  bit         pat_m;
  int         hs_low, vs_low_s, req_cnt_s, last_fs_s, found;

  initial begin
    vecs.push_back('{0,     1'b0, 8'h00, 10'd0,   10'd0,  8'h00, 1'b1});
    vecs.push_back('{2,     1'b0, 8'h00, 10'd1,   10'd0,  8'h00, 1'b1});
    vecs.push_back('{1409,  1'b0, 8'h00, 10'd704, 10'd0,  8'h00, 1'b1});
    vecs.push_back('{1410,  1'b0, 8'h00, 10'd705, 10'd0,  8'h00, 1'b0});
    vecs.push_back('{1599,  1'b0, 8'h00, 10'd799, 10'd0,  8'h00, 1'b0});
    vecs.push_back('{1600,  1'b0, 8'h00, 10'd0,   10'd1,  8'h00, 1'b0});
    vecs.push_back('{1602,  1'b0, 8'h00, 10'd1,   10'd1,  8'h00, 1'b1});
    vecs.push_back('{52898, 1'b1, 8'hA5, 10'd49,  10'd33, 8'hA5, 1'b1});
    vecs.push_back('{54178, 1'b1, 8'hFF, 10'd689, 10'd33, 8'h00, 1'b1});
`ifdef VGA_TEST_PATTERN_EN
    vecs.push_back('{54498, 1'b1, 8'hFF, 10'd49,  10'd34, 8'h00, 1'b1});
    vecs.push_back('{55618, 1'b1, 8'h00, 10'd609, 10'd34, 8'hFF, 1'b1});
`endif

    rst_n = 1'b0; rst_s = 1'b0; test_en = 1'b0;
    nc_m = 8'h3C; nc_s = 8'hC3;
    held_m = 8'h00; held_s = 8'h00; pat_m = 1'b0;
    hs_low = 0; vs_low_s = 0; req_cnt_s = 0; last_fs_s = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_obs("rst_m", {col_m, row_m, req_m, rgb_m, hs_m, vs_m, fs_m}, {10'd0, 10'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0});
    cmp_obs("rst_s", {col_s, row_s, req_s, rgb_s, hs_s, vs_s, fs_s}, {10'd0, 10'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0});

    rst_n = 1'b1; rst_s = 1'b1;
    apply_vectors(0);
    nc_m = forced_or_rand(0, 8'($urandom));
    nc_s = 8'($urandom);

    for (int n = 1; n <= N_RUN && errors < 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      cmp_obs("m", {col_m, row_m, req_m, rgb_m, hs_m, vs_m, fs_m}, model(n, HM, VM, held_m, pat_m));
      cmp_obs("s", {col_s, row_s, req_s, rgb_s, hs_s, vs_s, fs_s}, model(n, HS, VS, held_s, 1'b0));
      apply_vectors(n);

      // Small-geometry frame wrap: col 199,row 49 -> col 0,row 0 with a one-clk frame_start.
      if (n == 19999) begin
        chk("wrap.col_last", 32'(col_s), 32'd199);
        chk("wrap.row_last", 32'(row_s), 32'd49);
      end
      if (n == 20000) begin
        chk("wrap.col0", 32'(col_s), 32'd0);
        chk("wrap.row0", 32'(row_s), 32'd0);
        chk("wrap.fs",   32'(fs_s),  32'd1);
      end
      if (n == 20001) chk("wrap.fs_drop", 32'(fs_s), 32'd0);

      // hsync low 192 clk in every 1600-clk line window.
      if (n >= 2) begin
        hs_low += (hs_m == 1'b0) ? 1 : 0;
        vs_low_s += (vs_s == 1'b0) ? 1 : 0;
        if ((n - 2) % 1600 == 1599) begin
          chk("hsync_low_per_line", 32'(hs_low), 32'd192);
          hs_low = 0;
        end
        if ((n - 2) % 20000 == 19999) begin
          chk("vsync_low_per_frame_s", 32'(vs_low_s), 32'd800);
          vs_low_s = 0;
        end
      end
      req_cnt_s += req_s ? 1 : 0;
      if (n % 20000 == 19999) begin
        chk("req_per_frame_s", 32'(req_cnt_s), 32'd200);
        req_cnt_s = 0;
      end
      if (fs_s) begin
        if (last_fs_s > 0) chk("frame_period_s", 32'(n - last_fs_s), 32'd20000);
        last_fs_s = n;
      end

`ifdef VGA_TEST_PATTERN_EN
      if (n == 54180) test_en = 1'b1;
`endif
      nc_m = forced_or_rand(n, 8'($urandom));
      nc_s = 8'($urandom);
      if (n % 2 == 1) begin
        held_m = nc_m;
        pat_m  = test_en;
        held_s = nc_s;
      end
    end

    // Mid-line asynchronous reset at col 300, then restart from the origin.
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clk);
      if (col_m == 10'd300) found = 1;
    end
    chk("wait_col300", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    cmp_obs("async_rst", {col_m, row_m, req_m, rgb_m, hs_m, vs_m, fs_m}, {10'd0, 10'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0});
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold.col", 32'(col_m), 32'd0);
    rst_n = 1'b1;
    chk("rel.col", 32'(col_m), 32'd0);
    chk("rel.row", 32'(row_m), 32'd0);
    chk("rel.req", 32'(req_m), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rel1.col", 32'(col_m), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rel2.col",   32'(col_m), 32'd1);
    chk("rel2.row",   32'(row_m), 32'd0);
    chk("rel2.rgb",   32'(rgb_m), 32'd0);
    chk("rel2.hsync", 32'(hs_m),  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
